// File: rtl/instr_sequencer_if.sv
// Instruction sequencer bus bundle.
// Carries the instruction-memory read port (im_req/im_addr/im_ack/im_data)
// and the decoded-instruction issue port (issue_valid/issue_ready plus the
// op_code/rd/rs1/rs2 fields) between the sequencer and its neighbours.
//   master : the sequencer (drives requests, addresses, issue fields)
//   slave  : memory/datapath side (drives ack, data, ready)
interface instr_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_ack;
    logic [31:0]       im_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [6:0]        op_code;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;

    modport master (
        output im_req, im_addr, issue_valid, op_code, rd, rs1, rs2,
        input  im_ack, im_data, issue_ready
    );

    modport slave (
        input  im_req, im_addr, issue_valid, op_code, rd, rs1, rs2,
        output im_ack, im_data, issue_ready
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 32-bit instruction words from instruction memory,
// decodes them and issues rs1/rs2/rd/op_code to the datapath, one instruction
// per valid/ready handshake. Runs PROG_LEN words starting at pc=0 per start.
// Ports:
//   clk      clock, all state changes on posedge
//   reset    synchronous active-high reset
//   start    one-cycle pulse, starts a run when not busy
//   bus      instr_sequencer_if.master (memory read port + issue port)
//   busy     run in progress (FETCH/DECODE/ISSUE)
//   done     sticky: run completed normally
//   illegal  sticky: unsupported op_code fetched
//   pc       current program counter
module instr_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int PROG_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    instr_sequencer_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [ADDR_W-1:0]  pc
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        DONE,
        ERROR
    } state_t;

    localparam logic [6:0]        OP_NOP   = 7'h00;
    localparam logic [6:0]        OP_STORE = 7'h01;
    localparam logic [6:0]        OP_ADD   = 7'h02;
    localparam logic [6:0]        OP_SUB   = 7'h03;
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);

    state_t     state;
    logic [6:0] instr_op;
    logic [4:0] instr_rd;
    logic [4:0] instr_rs1;
    logic [4:0] instr_rs2;
    logic       last_word;

    assign bus.im_addr = pc;
    assign busy        = (state == FETCH) || (state == DECODE) || (state == ISSUE);
    assign last_word   = (pc == LAST_PC);

    // Main sequencer. Only the decoded fields are kept from the fetched word;
    // the remaining instruction bits carry nothing this sequencer uses.
    // Retiring (a NOP in DECODE or an accepted issue) either finishes the run
    // on the last word or advances pc and goes straight back to FETCH with
    // the request already raised, which gives the 3-cycle issue / 2-cycle NOP
    // minimum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= '0;
            bus.im_req      <= 1'b0;
            bus.issue_valid <= 1'b0;
            bus.op_code     <= '0;
            bus.rd          <= '0;
            bus.rs1         <= '0;
            bus.rs2         <= '0;
            done            <= 1'b0;
            illegal         <= 1'b0;
            instr_op        <= '0;
            instr_rd        <= '0;
            instr_rs1       <= '0;
            instr_rs2       <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        pc         <= '0;
                        done       <= 1'b0;
                        illegal    <= 1'b0;
                        bus.im_req <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.im_ack) begin
                        instr_op   <= bus.im_data[6:0];
                        instr_rd   <= bus.im_data[11:7];
                        instr_rs1  <= bus.im_data[19:15];
                        instr_rs2  <= bus.im_data[24:20];
                        bus.im_req <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    bus.op_code <= instr_op;
                    bus.rd      <= instr_rd;
                    bus.rs1     <= instr_rs1;
                    bus.rs2     <= instr_rs2;
                    case (instr_op)
                        OP_NOP: begin
                            if (last_word) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                pc         <= pc + ADDR_W'(1);
                                bus.im_req <= 1'b1;
                                state      <= FETCH;
                            end
                        end
                        OP_STORE, OP_ADD, OP_SUB: begin
                            bus.issue_valid <= 1'b1;
                            state           <= ISSUE;
                        end
                        default: begin
                            // pc is left on the offending word for diagnosis
                            illegal <= 1'b1;
                            state   <= ERROR;
                        end
                    endcase
                end
                ISSUE: begin
                    if (bus.issue_ready) begin
                        bus.issue_valid <= 1'b0;
                        if (last_word) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pc         <= pc + ADDR_W'(1);
                            bus.im_req <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer. dut_a (PROG_LEN=1) covers the single-ADD
// run; dut_b (PROG_LEN=32) covers reset, backpressure, memory wait,
// NOP/illegal handling and a full randomised run. A negedge responder plays
// memory and datapath for dut_b and keeps a scoreboard of expected issues.
module tb_instr_sequencer;
    typedef struct {
        logic [4:0]  pc;
        logic [21:0] fields;
    } exp_t;

    typedef enum {ACK_FIXED, ACK_RANDOM} ack_mode_t;
    typedef enum {RDY_FIXED, RDY_HOLD, RDY_RANDOM} rdy_mode_t;

    localparam logic [31:0] GARBAGE = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a;
    logic       start_b;
    logic       busy_a, done_a, illegal_a;
    logic       busy_b, done_b, illegal_b;
    logic [4:0] pc_a, pc_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [32];
    exp_t        sb[$];
    int          transfers   = 0;
    int          req_cycles  = 0;
    int          valid_cycles = 0;
    int          ack_delay   = 0;
    int          ready_stall = 0;
    logic [4:0]  req_addr0   = '0;
    ack_mode_t   ack_mode    = ACK_FIXED;
    rdy_mode_t   rdy_mode    = RDY_FIXED;

    always #5 clk = ~clk;

    instr_sequencer_if #(.ADDR_W(5)) bus_a ();
    instr_sequencer_if #(.ADDR_W(5)) bus_b ();

    instr_sequencer #(.ADDR_W(5), .PROG_LEN(1)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .start   (start_a),
        .bus     (bus_a),
        .busy    (busy_a),
        .done    (done_a),
        .illegal (illegal_a),
        .pc      (pc_a)
    );

    instr_sequencer #(.ADDR_W(5), .PROG_LEN(32)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .start   (start_b),
        .bus     (bus_b),
        .busy    (busy_b),
        .done    (done_b),
        .illegal (illegal_b),
        .pc      (pc_b)
    );

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    function automatic logic [21:0] fields_of(input logic [31:0] d);
        return {d[6:0], d[11:7], d[19:15], d[24:20]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start_b for one cycle; returns with dut_b in FETCH.
    task automatic applyStimulus();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        req_cycles   = 0;
        valid_cycles = 0;
    endtask

    // Memory and datapath model for dut_b. Decisions are made on the falling
    // edge so they are stable at the next rising edge. Every acked word with a
    // supported op is pushed as an expected issue; every cycle with
    // issue_valid high is checked against the head of the queue.
    always @(negedge clk) begin
        logic give;
        logic rdy;
        logic [31:0] d;
        if (bus_b.im_req) begin
            if (req_cycles == 0)
                req_addr0 = bus_b.im_addr;
            else
                checkOutput("im_addr_hold", 32'(bus_b.im_addr), 32'(req_addr0));
            req_cycles++;
            if (ack_mode == ACK_RANDOM)
                give = 1'($urandom_range(0, 1));
            else
                give = (req_cycles > ack_delay);
            if (give) begin
                d = mem[bus_b.im_addr];
                bus_b.im_ack  = 1'b1;
                bus_b.im_data = d;
                if (d[6:0] inside {7'h01, 7'h02, 7'h03})
                    sb.push_back('{pc: bus_b.im_addr, fields: fields_of(d)});
                req_cycles = 0;
            end else begin
                bus_b.im_ack  = 1'b0;
                bus_b.im_data = GARBAGE;
            end
        end else begin
            bus_b.im_ack  = (ack_mode == ACK_RANDOM) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_b.im_data = GARBAGE;
            req_cycles    = 0;
        end

        if (bus_b.issue_valid) begin
            valid_cycles++;
            case (rdy_mode)
                RDY_RANDOM: rdy = 1'($urandom_range(0, 1));
                RDY_HOLD:   rdy = 1'b0;
                default:    rdy = (valid_cycles > ready_stall);
            endcase
            bus_b.issue_ready = rdy;
            if (sb.size() == 0) begin
                checkOutput("unexpected_issue", 32'(bus_b.issue_valid), 32'd0);
            end else begin
                checkOutput("issue_fields",
                            32'({bus_b.op_code, bus_b.rd, bus_b.rs1, bus_b.rs2}),
                            32'(sb[0].fields));
                checkOutput("issue_pc", 32'(pc_b), 32'(sb[0].pc));
                if (rdy) begin
                    void'(sb.pop_front());
                    transfers++;
                    valid_cycles = 0;
                end
            end
        end else begin
            bus_b.issue_ready = (rdy_mode == RDY_RANDOM) ? 1'($urandom_range(0, 1)) : 1'b0;
            valid_cycles      = 0;
        end
    end

    initial begin
        int cyc;
        int t0;
        reset             = 1'b1;
        start_a           = 1'b0;
        start_b           = 1'b0;
        bus_a.im_ack      = 1'b1;
        bus_a.im_data     = 32'h0031_0502;
        bus_a.issue_ready = 1'b1;
        bus_b.im_ack      = 1'b0;
        bus_b.im_data     = GARBAGE;
        bus_b.issue_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = enc(7'h02, 5'd1, 5'd2, 5'd3);

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy_b), 32'd0);
        checkOutput("rst_done", 32'(done_b), 32'd0);
        checkOutput("rst_illegal", 32'(illegal_b), 32'd0);
        checkOutput("rst_pc", 32'(pc_b), 32'd0);
        checkOutput("rst_im_req", 32'(bus_b.im_req), 32'd0);
        checkOutput("rst_valid", 32'(bus_b.issue_valid), 32'd0);
        checkOutput("rst_fields", 32'({bus_b.op_code, bus_b.rd, bus_b.rs1, bus_b.rs2}), 32'd0);
        reset = 1'b0;
        tick();

        // Reset while stalled in ISSUE
        $display("[TB] reset mid-issue");
        rdy_mode = RDY_HOLD;
        applyStimulus();
        cyc = 0;
        while (!bus_b.issue_valid && cyc < 20) begin tick(); cyc++; end
        checkOutput("t1_reach_issue", 32'(bus_b.issue_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        checkOutput("t1_valid", 32'(bus_b.issue_valid), 32'd0);
        checkOutput("t1_pc", 32'(pc_b), 32'd0);
        checkOutput("t1_busy", 32'(busy_b), 32'd0);
        checkOutput("t1_flags", 32'({done_b, illegal_b}), 32'd0);
        tick();
        tick();
        checkOutput("t1_idle_hold", 32'({bus_b.im_req, busy_b}), 32'd0);

        // Single ADD on the PROG_LEN=1 instance
        $display("[TB] single ADD");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (!bus_a.issue_valid && cyc < 20) begin tick(); cyc++; end
        checkOutput("a_latency", 32'(cyc), 32'd2);
        checkOutput("a_op", 32'(bus_a.op_code), 32'h02);
        checkOutput("a_rd", 32'(bus_a.rd), 32'd10);
        checkOutput("a_rs1", 32'(bus_a.rs1), 32'd2);
        checkOutput("a_rs2", 32'(bus_a.rs2), 32'd3);
        tick();
        checkOutput("a_valid_drop", 32'(bus_a.issue_valid), 32'd0);
        checkOutput("a_done", 32'(done_a), 32'd1);
        checkOutput("a_busy", 32'(busy_a), 32'd0);

        // Backpressure: ready low for 4 cycles on a SUB
        $display("[TB] backpressure");
        reset_dut();
        mem[0]      = enc(7'h03, 5'd14, 5'd4, 5'd5);
        rdy_mode    = RDY_FIXED;
        ready_stall = 4;
        t0          = transfers;
        applyStimulus();
        cyc = 0;
        while (!bus_b.issue_valid && cyc < 20) begin tick(); cyc++; end
        cyc = 0;
        while (bus_b.issue_valid && cyc < 20) begin tick(); cyc++; end
        checkOutput("t3_valid_len", 32'(cyc), 32'd5);
        checkOutput("t3_transfers", 32'(transfers - t0), 32'd1);
        checkOutput("t3_pc", 32'(pc_b), 32'd1);

        // Memory wait: ack three cycles late
        $display("[TB] memory wait");
        reset_dut();
        mem[0]      = enc(7'h02, 5'd7, 5'd8, 5'd9);
        ready_stall = 0;
        ack_delay   = 3;
        t0          = transfers;
        applyStimulus();
        cyc = 0;
        while (bus_b.im_req && cyc < 20) begin tick(); cyc++; end
        checkOutput("t4_req_len", 32'(cyc), 32'd4);
        cyc = 0;
        while (transfers == t0 && cyc < 20) begin tick(); cyc++; end
        checkOutput("t4_transfers", 32'(transfers - t0), 32'd1);
        checkOutput("t4_illegal", 32'(illegal_b), 32'd0);

        // NOP, STORE, illegal op, then restart
        $display("[TB] NOP and illegal");
        reset_dut();
        ack_delay = 0;
        mem[0]    = 32'h0000_0000;
        mem[1]    = enc(7'h01, 5'd4, 5'd5, 5'd6);
        mem[2]    = enc(7'h7F, 5'd1, 5'd1, 5'd1);
        t0        = transfers;
        applyStimulus();
        cyc = 0;
        while (busy_b && cyc < 60) begin tick(); cyc++; end
        checkOutput("t5_illegal", 32'(illegal_b), 32'd1);
        checkOutput("t5_done", 32'(done_b), 32'd0);
        checkOutput("t5_pc", 32'(pc_b), 32'd2);
        checkOutput("t5_transfers", 32'(transfers - t0), 32'd1);
        tick();
        tick();
        checkOutput("t5_no_req", 32'({bus_b.im_req, busy_b}), 32'd0);
        applyStimulus();
        checkOutput("t5_restart_illegal", 32'(illegal_b), 32'd0);
        checkOutput("t5_restart_pc", 32'(pc_b), 32'd0);
        checkOutput("t5_restart_busy", 32'(busy_b), 32'd1);

        // Full 32-word run with random ack/ready and stray start pulses
        $display("[TB] full run");
        reset_dut();
        for (int i = 0; i < 32; i++) begin
            mem[i]      = $urandom;
            mem[i][6:0] = 7'h02;
        end
        ack_mode = ACK_RANDOM;
        rdy_mode = RDY_RANDOM;
        t0       = transfers;
        applyStimulus();
        cyc = 0;
        while (busy_b && cyc < 3000) begin
            start_b = (cyc % 37 == 5);
            tick();
            cyc++;
        end
        start_b = 1'b0;
        checkOutput("t6_done", 32'(done_b), 32'd1);
        checkOutput("t6_transfers", 32'(transfers - t0), 32'd32);
        checkOutput("t6_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("t6_pc", 32'(pc_b), 32'd31);
        checkOutput("t6_illegal", 32'(illegal_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
